// File: rtl/dma_mem_ctrl.sv
// rtl/dma_mem_ctrl.sv - Bus-to-SRAM controller: single-beat writes and block-read bursts
// after a fixed number of wait states.
module dma_mem_ctrl #(
  parameter int dma_data_width_p  = 1,
  parameter int block_width_p     = 4,
  parameter int wait_cycles_p     = 2,
  parameter int sram_addr_width_p = 10
) (
  input  logic                            clk_i,
  input  logic                            nreset_i,
  input  logic                            mem_valid_i,
  output logic                            mem_ready_o,
  input  logic                            mem_we_i,
  input  logic [31:0]                     mem_addr_i,
  input  logic [dma_data_width_p*32-1:0]  mem_wdata_i,
  output logic                            mem_valid_o,
  output logic [dma_data_width_p*32-1:0]  mem_data_o,
  output logic                            sram_en_o,
  output logic                            sram_we_o,
  output logic [sram_addr_width_p-1:0]    sram_addr_o,
  output logic [dma_data_width_p*32-1:0]  sram_wdata_o,
  input  logic [dma_data_width_p*32-1:0]  sram_rdata_i
);

  localparam int data_w_lp    = dma_data_width_p * 32;
  localparam int burst_len_lp = block_width_p / dma_data_width_p;
  localparam int burst_w_lp   = (burst_len_lp > 1) ? $clog2(burst_len_lp) : 1;
  localparam int wait_w_lp    = (wait_cycles_p > 1) ? $clog2(wait_cycles_p + 1) : 1;
  localparam int shift_lp     = 2 + $clog2(dma_data_width_p);

  typedef enum logic [1:0] {IDLE, WAIT, WR, RD} state_t;

  state_t                        state_q, state_d;
  logic [wait_w_lp-1:0]          wait_q, wait_d;
  logic [burst_w_lp-1:0]         burst_q, burst_d;
  logic                          we_q;
  logic [sram_addr_width_p-1:0]  idx_q;
  logic [data_w_lp-1:0]          wdata_q;
  logic                          valid_q;
  logic                          rd_strobe;
  logic                          accept;
  logic [31:0]                   beat_addr;
  logic [sram_addr_width_p-1:0]  base_idx;
  logic                          unused_beat_bits;

  assign mem_ready_o      = (state_q == IDLE) & nreset_i;
  assign accept           = mem_valid_i & mem_ready_o;
  assign beat_addr        = mem_addr_i >> shift_lp;
  assign unused_beat_bits = ^beat_addr;
  // Bursts always cover a whole aligned block regardless of the requested word.
  assign base_idx         = idx_q & ~sram_addr_width_p'(burst_len_lp - 1);
  assign mem_valid_o      = valid_q;
  assign mem_data_o       = sram_rdata_i;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    burst_d      = burst_q;
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = idx_q;
    sram_wdata_o = wdata_q;
    rd_strobe    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          burst_d = '0;
          if (wait_cycles_p > 0) begin
            state_d = WAIT;
            wait_d  = wait_w_lp'(wait_cycles_p);
          end else begin
            state_d = mem_we_i ? WR : RD;
          end
        end
      end
      WAIT: begin
        wait_d = wait_q - wait_w_lp'(1);
        if (wait_q <= wait_w_lp'(1)) state_d = we_q ? WR : RD;
      end
      WR: begin
        sram_en_o = 1'b1;
        sram_we_o = 1'b1;
        state_d   = IDLE;
      end
      RD: begin
        sram_en_o   = 1'b1;
        sram_addr_o = base_idx + sram_addr_width_p'(burst_q);
        rd_strobe   = 1'b1;
        if (burst_q == burst_w_lp'(burst_len_lp - 1)) begin
          state_d = IDLE;
          burst_d = '0;
        end else begin
          burst_d = burst_q + burst_w_lp'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
      burst_q <= '0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
      valid_q <= rd_strobe;
      if (accept) begin
        we_q    <= mem_we_i;
        idx_q   <= beat_addr[sram_addr_width_p-1:0];
        wdata_q <= mem_wdata_i;
      end
    end
  end

endmodule
